// File: rtl/pc_pkg.sv
// Shared encodings for the program-counter sequencer: next-PC select modes
// and the sequencer FSM state type.
package pc_pkg;

  localparam logic [2:0] SEL_SEQ    = 3'd0;
  localparam logic [2:0] SEL_BRANCH = 3'd1;
  localparam logic [2:0] SEL_JAL    = 3'd2;
  localparam logic [2:0] SEL_JALR   = 3'd3;
  localparam logic [2:0] SEL_TRAP   = 3'd4;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } pc_state_e;

  // Only RUN presents a usable fetch address.
  function automatic logic fetch_valid(input pc_state_e s);
    return (s == ST_RUN);
  endfunction

endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-PC target selection with alignment check; a misaligned
// branch/jump target is redirected to the trap vector.
module pc_next_calc
  import pc_pkg::*;
#(
  parameter int unsigned           XLEN        = 32,
  parameter logic [XLEN-1:0]       TRAP_VECTOR = 32'h0000_0100,
  parameter int unsigned           ILEN_BYTES  = 4
) (
  input  logic [XLEN-1:0] pc,
  input  logic [2:0]      next_sel,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] imediato,
  input  logic [XLEN-1:0] rs1_value,
  output logic [XLEN-1:0] target,
  output logic [XLEN-1:0] next_pc,
  output logic            misaligned
);

  localparam logic [XLEN-1:0] STEP       = XLEN'(ILEN_BYTES);
  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(ILEN_BYTES - 1);

  logic [XLEN-1:0] seq_pc;
  logic [XLEN-1:0] rel_pc;
  logic [XLEN-1:0] jalr_sum;
  logic            check_align;

  assign seq_pc   = pc + STEP;
  assign rel_pc   = pc + imediato;
  assign jalr_sum = rs1_value + imediato;

  // Reserved encodings fall through to sequential flow; only computed
  // branch/jump targets are subject to the alignment check.
  always_comb begin
    target      = seq_pc;
    check_align = 1'b0;
    case (next_sel)
      SEL_SEQ: begin
        target = seq_pc;
      end
      SEL_BRANCH: begin
        check_align = 1'b1;
        target      = branch_taken ? rel_pc : seq_pc;
      end
      SEL_JAL: begin
        check_align = 1'b1;
        target      = rel_pc;
      end
      SEL_JALR: begin
        check_align = 1'b1;
        target      = {jalr_sum[XLEN-1:1], 1'b0};
      end
      SEL_TRAP: begin
        target = TRAP_VECTOR;
      end
      default: begin
        target = seq_pc;
      end
    endcase
  end

  assign misaligned = check_align && ((target & ALIGN_MASK) != '0);
  assign next_pc    = misaligned ? TRAP_VECTOR : target;

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: BOOT/RUN/HALT control around a registered PC,
// with misaligned-target trapping and capture of the offending address.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'h0000_0100,
  parameter int unsigned     ILEN_BYTES   = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            stall,
  input  logic [2:0]      next_sel,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] imediato,
  input  logic [XLEN-1:0] rs1_value,
  input  logic            halt_req,
  input  logic            resume,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_link,
  output logic            pc_valid,
  output logic            misaligned,
  output logic [XLEN-1:0] bad_addr,
  output logic [1:0]      state
);

  pc_state_e       state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] bad_q, bad_d;
  logic            mis_q, mis_d;

  logic [XLEN-1:0] calc_target;
  logic [XLEN-1:0] calc_next;
  logic            calc_mis;

  pc_next_calc #(
    .XLEN        (XLEN),
    .TRAP_VECTOR (TRAP_VECTOR),
    .ILEN_BYTES  (ILEN_BYTES)
  ) u_next_calc (
    .pc           (pc_q),
    .next_sel     (next_sel),
    .branch_taken (branch_taken),
    .imediato     (imediato),
    .rs1_value    (rs1_value),
    .target       (calc_target),
    .next_pc      (calc_next),
    .misaligned   (calc_mis)
  );

  // halt_req outranks stall and next_sel; misaligned is a single-cycle pulse.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    bad_d   = bad_q;
    mis_d   = 1'b0;
    case (state_q)
      ST_BOOT: begin
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (halt_req) begin
          state_d = ST_HALT;
        end else if (!stall) begin
          pc_d = calc_next;
          if (calc_mis) begin
            mis_d = 1'b1;
            bad_d = calc_target;
          end
        end
      end
      ST_HALT: begin
        if (resume && !halt_req) begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_BOOT;
        pc_d    = RESET_VECTOR;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_VECTOR;
      bad_q   <= '0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      bad_q   <= bad_d;
      mis_q   <= mis_d;
    end
  end

  assign pc         = pc_q;
  assign pc_link    = pc_q + XLEN'(ILEN_BYTES);
  assign pc_valid   = fetch_valid(state_q);
  assign misaligned = mis_q;
  assign bad_addr   = bad_q;
  assign state      = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus randomized
// traffic, all compared against a behavioural model of the PC rules.
module tb_pc_sequencer;

  localparam logic [31:0] RESET_VEC = 32'h0000_0000;
  localparam logic [31:0] TRAP_VEC  = 32'h0000_0100;
  localparam int          ILEN      = 4;
  localparam int          M_BOOT = 0, M_RUN = 1, M_HALT = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic [2:0]  next_sel = 3'd0;
  logic        branch_taken = 1'b0;
  logic [31:0] imediato = '0;
  logic [31:0] rs1_value = '0;
  logic        halt_req = 1'b0;
  logic        resume = 1'b0;
  logic [31:0] pc, pc_link, bad_addr;
  logic        pc_valid, misaligned;
  logic [1:0]  state;

  int testsRun    = 0;
  int testsFailed = 0;

  logic [31:0] mPc, mBad;
  logic        mMis;
  int          mState;

  pc_sequencer #(
    .XLEN         (32),
    .RESET_VECTOR (RESET_VEC),
    .TRAP_VECTOR  (TRAP_VEC),
    .ILEN_BYTES   (ILEN)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .stall        (stall),
    .next_sel     (next_sel),
    .branch_taken (branch_taken),
    .imediato     (imediato),
    .rs1_value    (rs1_value),
    .halt_req     (halt_req),
    .resume       (resume),
    .pc           (pc),
    .pc_link      (pc_link),
    .pc_valid     (pc_valid),
    .misaligned   (misaligned),
    .bad_addr     (bad_addr),
    .state        (state)
  );

  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: actual=0x%08h required=0x%08h", tag, actual, expected);
    end
  endtask

  task automatic checkAll(input string pfx);
    checkOutput({pfx, ".pc"},       pc,                 mPc);
    checkOutput({pfx, ".pc_link"},  pc_link,            mPc + 32'd4);
    checkOutput({pfx, ".pc_valid"}, {31'd0, pc_valid},  {31'd0, mState == M_RUN});
    checkOutput({pfx, ".misalign"}, {31'd0, misaligned}, {31'd0, mMis});
    checkOutput({pfx, ".bad_addr"}, bad_addr,           mBad);
    checkOutput({pfx, ".state"},    {30'd0, state},     32'(mState));
  endtask

  function automatic void modelReset();
    mPc    = RESET_VEC;
    mBad   = '0;
    mMis   = 1'b0;
    mState = M_BOOT;
  endfunction

  // Reference behaviour for one clock edge, derived from the PC rules.
  function automatic void modelStep(input logic st, input logic [2:0] sel, input logic bt,
                                    input logic [31:0] imm, input logic [31:0] rs1,
                                    input logic hr, input logic rs);
    logic [31:0] tgt;
    logic        chk;
    mMis = 1'b0;
    if (mState == M_BOOT) begin
      mState = M_RUN;
    end else if (mState == M_HALT) begin
      if (rs && !hr) mState = M_RUN;
    end else if (hr) begin
      mState = M_HALT;
    end else if (!st) begin
      chk = (sel == 3'd1 || sel == 3'd2 || sel == 3'd3);
      if (sel == 3'd1)      tgt = bt ? mPc + imm : mPc + 32'd4;
      else if (sel == 3'd2) tgt = mPc + imm;
      else if (sel == 3'd3) tgt = ((rs1 + imm) / 2) * 2;
      else if (sel == 3'd4) tgt = TRAP_VEC;
      else                  tgt = mPc + 32'd4;
      if (chk && (tgt % ILEN) != 0) begin
        mPc  = TRAP_VEC;
        mMis = 1'b1;
        mBad = tgt;
      end else begin
        mPc = tgt;
      end
    end
  endfunction

  // Called #1 after a rising edge; drives inputs, steps one edge, checks.
  task automatic applyStimulus(input string tag, input logic st, input logic [2:0] sel,
                               input logic bt, input logic [31:0] imm, input logic [31:0] rs1,
                               input logic hr, input logic rs);
    stall = st; next_sel = sel; branch_taken = bt; imediato = imm;
    rs1_value = rs1; halt_req = hr; resume = rs;
    modelStep(st, sel, bt, imm, rs1, hr, rs);
    @(posedge clock);
    #1;
    checkAll(tag);
  endtask

  // Asserts reset away from an edge, checks the asynchronous effect, then releases.
  task automatic doReset(input string tag);
    reset = 1'b0;
    #1;
    modelReset();
    checkAll({tag, ".async"});
    @(posedge clock);
    #1;
    checkAll({tag, ".held"});
    reset = 1'b1;
    checkAll({tag, ".boot"});
  endtask

  initial begin
    modelReset();
    doReset("por");

    applyStimulus("boot_ignore", 1'b1, 3'd4, 1'b1, 32'd0, 32'd0, 1'b1, 1'b0);
    applyStimulus("seq1", 1'b0, 3'd0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    applyStimulus("seq2", 1'b0, 3'd0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    applyStimulus("seq3", 1'b0, 3'd0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);

    applyStimulus("jal_to8",    1'b0, 3'd2, 1'b0, -32'sd4, 32'd0, 1'b0, 1'b0);
    applyStimulus("br_taken",   1'b0, 3'd1, 1'b1, -32'sd8, 32'd0, 1'b0, 1'b0);
    applyStimulus("br_not",     1'b0, 3'd1, 1'b0, -32'sd8, 32'd0, 1'b0, 1'b0);
    applyStimulus("jal_to10",   1'b0, 3'd2, 1'b0, 32'd12, 32'd0, 1'b0, 1'b0);
    applyStimulus("jalr_odd",   1'b0, 3'd3, 1'b0, 32'd2, 32'h21, 1'b0, 1'b0);
    applyStimulus("mis_clear",  1'b0, 3'd0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    applyStimulus("jalr_ok",    1'b0, 3'd3, 1'b0, 32'd3, 32'h21, 1'b0, 1'b0);
    applyStimulus("jal_mis",    1'b0, 3'd2, 1'b0, 32'd6, 32'd0, 1'b0, 1'b0);
    applyStimulus("stall_mis",  1'b1, 3'd2, 1'b0, 32'd6, 32'd0, 1'b0, 1'b0);
    applyStimulus("trap",       1'b0, 3'd4, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    applyStimulus("rsvd7",      1'b0, 3'd7, 1'b1, 32'd6, 32'd0, 1'b0, 1'b0);

    applyStimulus("jalr_top",   1'b0, 3'd3, 1'b0, 32'hC, 32'hFFFF_FFF0, 1'b0, 1'b0);
    applyStimulus("wrap",       1'b0, 3'd0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    applyStimulus("stall1",     1'b1, 3'd2, 1'b1, 32'd40, 32'd0, 1'b0, 1'b0);
    applyStimulus("stall2",     1'b1, 3'd0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);

    applyStimulus("halt_enter", 1'b1, 3'd2, 1'b0, 32'd64, 32'd0, 1'b1, 1'b0);
    applyStimulus("halt_both",  1'b0, 3'd0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1);
    applyStimulus("halt_hold",  1'b0, 3'd2, 1'b0, 32'd8, 32'd0, 1'b0, 1'b0);
    applyStimulus("resume",     1'b0, 3'd0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
    applyStimulus("run_again",  1'b0, 3'd0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    applyStimulus("halt2",      1'b0, 3'd0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    doReset("rst_halt");
    applyStimulus("boot2", 1'b0, 3'd2, 1'b0, 32'd16, 32'd0, 1'b0, 1'b0);

    for (int i = 0; i < 600; i++) begin
      logic [31:0] imm;
      logic [31:0] rs1;
      int          mag;
      mag = int'($urandom_range(0, 31)) - 16;
      imm = ($urandom_range(0, 3) == 0) ? 32'(mag) : 32'(mag * 4);
      rs1 = ($urandom_range(0, 1) == 0) ? $urandom : {24'd0, 8'($urandom)};
      if ($urandom_range(0, 99) == 0) begin
        doReset("rand_rst");
      end else begin
        applyStimulus("rand",
                      $urandom_range(0, 4) == 0,
                      3'($urandom_range(0, 7)),
                      1'($urandom),
                      imm, rs1,
                      $urandom_range(0, 9) == 0,
                      $urandom_range(0, 2) == 0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
